// File: rtl/mem_region_router.sv
// Registered base/limit address decoder routing one CPU request at a time to NUM_REGIONS slaves.
// Optional build macro MEM_ROUTER_ALIGN_CHECK_EN rejects word-misaligned addresses as decode errors.
module mem_region_router #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_REGIONS = 4,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  =
    {32'h0006_0000, 32'h0005_0000, 32'h0004_0000, 32'h0000_0000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT =
    {32'h0008_0000, 32'h0006_0000, 32'h0005_0000, 32'h0004_0000},
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [DATA_W-1:0]             cpu_wdata,
  output logic [DATA_W-1:0]             cpu_rdata,
  output logic                          cpu_ready,
  output logic                          cpu_err,
  output logic [NUM_REGIONS-1:0]        mem_select,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_we,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [NUM_REGIONS*DATA_W-1:0] mem_rdata,
  input  logic [NUM_REGIONS-1:0]        mem_ack
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [7:0]             TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [NUM_REGIONS-1:0] ONE_R    = NUM_REGIONS'(1'b1);

  state_e                   state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [NUM_REGIONS-1:0]   sel_q, sel_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic                     we_q, we_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d;
  logic                     ready_q, ready_d;
  logic                     err_q, err_d;

  logic [NUM_REGIONS-1:0]   in_win_s;
  logic [NUM_REGIONS-1:0]   first_s;
  logic [ADDR_W-1:0]        base_sel_s;
  logic [DATA_W-1:0]        rdata_sel_s;
  logic                     hit_s;
  logic                     ack_hit_s;
  logic                     misalign_s;

`ifdef MEM_ROUTER_ALIGN_CHECK_EN
  assign misalign_s = (cpu_addr[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif

  // Window decode; an empty window (base >= limit) can never satisfy both compares.
  always_comb begin
    in_win_s    = '0;
    base_sel_s  = '0;
    rdata_sel_s = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      in_win_s[i] = (cpu_addr >= REGION_BASE[i*ADDR_W +: ADDR_W]) &&
                    (cpu_addr <  REGION_LIMIT[i*ADDR_W +: ADDR_W]);
    end
    // Isolating the lowest set bit gives lowest-index priority on overlap.
    first_s = in_win_s & (~in_win_s + ONE_R);
    for (int i = 0; i < NUM_REGIONS; i++) begin
      base_sel_s  |= first_s[i] ? REGION_BASE[i*ADDR_W +: ADDR_W] : '0;
      rdata_sel_s |= sel_q[i]   ? mem_rdata[i*DATA_W +: DATA_W]   : '0;
    end
  end

  assign hit_s     = |in_win_s;
  assign ack_hit_s = |(mem_ack & sel_q);

  // Next-state and registered-output computation for the IDLE/ACCESS/RESP sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = '0;
    ready_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          if (hit_s && !misalign_s) begin
            state_d = ST_ACCESS;
            sel_d   = first_s;
            addr_d  = cpu_addr - base_sel_s;
            we_d    = cpu_we;
            wdata_d = cpu_wdata;
            cnt_d   = 8'd0;
          end else begin
            state_d = ST_RESP;
            ready_d = 1'b1;
            err_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // Ack is tested first so an ack on the timeout edge still completes cleanly.
        if (ack_hit_s) begin
          state_d = ST_RESP;
          ready_d = 1'b1;
          rdata_d = we_q ? '0 : rdata_sel_s;
          sel_d   = '0;
          we_d    = 1'b0;
          cnt_d   = 8'd0;
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_RESP;
          ready_d = 1'b1;
          err_d   = 1'b1;
          sel_d   = '0;
          we_d    = 1'b0;
          cnt_d   = 8'd0;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
        we_d    = 1'b0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight access silently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      sel_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign cpu_rdata  = rdata_q;
  assign cpu_ready  = ready_q;
  assign cpu_err    = err_q;
  assign mem_select = sel_q;
  assign mem_addr   = addr_q;
  assign mem_we     = we_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_region_router.sv
// Directed bench for mem_region_router: driver pushes expected responses, a monitor checks cpu_ready beats.
module tb_mem_region_router;

  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            cpu_req;
  logic            cpu_we;
  logic [31:0]     cpu_addr;
  logic [31:0]     cpu_wdata;
  logic [31:0]     cpu_rdata;
  logic            cpu_ready;
  logic            cpu_err;
  logic [NR-1:0]   mem_select;
  logic [31:0]     mem_addr;
  logic            mem_we;
  logic [31:0]     mem_wdata;
  logic [NR*32-1:0] mem_rdata;
  logic [NR-1:0]   mem_ack;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   req_cyc  = 0;

  mem_region_router dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .cpu_err    (cpu_err),
    .mem_select (mem_select),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every cpu_ready beat must match the oldest expected response.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && cpu_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready actual=1 required=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_rdata", 64'(cpu_rdata), 64'(e.rdata));
        check("resp_err", 64'(cpu_err), 64'(e.err));
        check("resp_latency", 64'(cyc - e.cyc), 64'(e.lat));
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk); #1;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    req_cyc   = cyc;
  endtask

  task automatic expect_resp(input logic [31:0] rdata, input logic err, input int lat);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.lat   = lat;
    e.cyc   = req_cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready_drop(input int bound, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(posedge clk); #1;
      if (cpu_ready === 1'b1) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd1);
    cpu_req   = 1'b0;
    cpu_addr  = 32'hFFFF_FFF0;
    cpu_wdata = 32'h0;
    mem_ack   = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    mem_rdata = '0;
    mem_ack   = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({cpu_rdata, cpu_ready, cpu_err, mem_select, mem_we}), 64'd0);
    check("reset_addr_wdata", {mem_addr, mem_wdata}, 64'd0);
    reset_n = 1'b1;

    // Read region0 near its limit, ack in the first ACCESS cycle.
    issue(1'b0, 32'h0003_FFFC, 32'h0);
    expect_resp(32'hDEAD_BEEF, 1'b0, 2);
    @(posedge clk); #1;
    check("rd0_select", 64'(mem_select), 64'h1);
    check("rd0_addr", 64'(mem_addr), 64'h3_FFFC);
    check("rd0_we", 64'(mem_we), 64'd0);
    mem_rdata[0*32 +: 32] = 32'hDEAD_BEEF;
    mem_ack = 4'b0001;
    wait_ready_drop(10, "rd0_ready_seen");
    check("rd0_resp_select_clear", 64'(mem_select), 64'd0);

    // Write region1, slave acks in the fourth ACCESS cycle; write returns zero data.
    issue(1'b1, 32'h0004_0010, 32'h1234_5678);
    expect_resp(32'h0, 1'b0, 5);
    mem_rdata[1*32 +: 32] = 32'hCAFE_F00D;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check("wr1_select", 64'(mem_select), 64'h2);
      check("wr1_we_held", 64'(mem_we), 64'd1);
      if (k == 4) mem_ack = 4'b0010;
    end
    check("wr1_addr", 64'(mem_addr), 64'h10);
    check("wr1_wdata", 64'(mem_wdata), 64'h1234_5678);
    wait_ready_drop(10, "wr1_ready_seen");
    check("wr1_resp_we_clear", 64'(mem_we), 64'd0);

    // Unmapped address and the exclusive top limit both decode-error in two cycles.
    issue(1'b0, 32'h0009_0000, 32'h0);
    expect_resp(32'h0, 1'b1, 1);
    wait_ready_drop(10, "nohit_ready_seen");
    check("nohit_select", 64'(mem_select), 64'd0);
    issue(1'b0, 32'h0008_0000, 32'h0);
    expect_resp(32'h0, 1'b1, 1);
    wait_ready_drop(10, "limit_ready_seen");
    check("limit_select", 64'(mem_select), 64'd0);

    // Region2 never acks; a spurious ack from slave0 must not complete it.
    issue(1'b0, 32'h0005_0000, 32'h0);
    expect_resp(32'h0, 1'b1, 256);
    @(posedge clk); #1;
    check("tmo_select", 64'(mem_select), 64'h4);
    check("tmo_addr", 64'(mem_addr), 64'h0);
    repeat (9) @(posedge clk);
    #1;
    mem_rdata[0*32 +: 32] = 32'h1111_1111;
    mem_ack = 4'b0001;
    @(posedge clk); #1;
    mem_ack = '0;
    check("tmo_spurious_ignored", 64'({cpu_ready, mem_select}), 64'h4);
    wait_ready_drop(300, "tmo_ready_seen");

    // Ack lands on the same edge as the timeout: ack wins.
    issue(1'b0, 32'h0005_FFF0, 32'h0);
    expect_resp(32'h0BAD_C0DE, 1'b0, 256);
    @(posedge clk); #1;
    check("tmoack_addr", 64'(mem_addr), 64'hFFF0);
    repeat (254) @(posedge clk);
    #1;
    mem_rdata[2*32 +: 32] = 32'h0BAD_C0DE;
    mem_ack = 4'b0100;
    wait_ready_drop(10, "tmoack_ready_seen");

    // Reset during ACCESS to region3: outputs clear at once, no ready pulse.
    issue(1'b0, 32'h0006_0008, 32'h5555_AAAA);
    @(posedge clk); #1;
    check("rst_pre_select", 64'(mem_select), 64'h8);
    check("rst_pre_addr", 64'(mem_addr), 64'h8);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_outputs",
          64'({cpu_rdata, cpu_ready, cpu_err, mem_select, mem_we}), 64'd0);
    check("rst_async_addr_wdata", {mem_addr, mem_wdata}, 64'd0);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    issue(1'b0, 32'h0006_0004, 32'h0);
    expect_resp(32'hA5A5_0003, 1'b0, 2);
    @(posedge clk); #1;
    check("post_rst_select", 64'(mem_select), 64'h8);
    check("post_rst_addr", 64'(mem_addr), 64'h4);
    mem_rdata[3*32 +: 32] = 32'hA5A5_0003;
    mem_ack = 4'b1000;
    wait_ready_drop(10, "post_rst_ready_seen");

    // Misaligned address into region0.
    issue(1'b0, 32'h0000_0002, 32'h0);
`ifdef MEM_ROUTER_ALIGN_CHECK_EN
    expect_resp(32'h0, 1'b1, 1);
    wait_ready_drop(10, "align_ready_seen");
    check("align_select", 64'(mem_select), 64'd0);
`else
    expect_resp(32'h7777_0002, 1'b0, 2);
    @(posedge clk); #1;
    check("align_select", 64'(mem_select), 64'h1);
    check("align_addr", 64'(mem_addr), 64'h2);
    mem_rdata[0*32 +: 32] = 32'h7777_0002;
    mem_ack = 4'b0001;
    wait_ready_drop(10, "align_ready_seen");
`endif

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_region_router.md
Name: mem_region_router

Overview:
- Parametrised, registered address decoder and request router between the pipeline's memory stage and NUM_REGIONS memory-mapped slaves (RAM, camera buffer, peripherals).
- Replaces the combinational 4-way memory select with programmable base/limit windows and a req/ack handshake.
- Adds per-region offset generation, read-data return muxing, decode-error and timeout reporting.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- NUM_REGIONS, 4, slave count (1..8).
- REGION_BASE, {32'h60000,32'h50000,32'h40000,32'h00000}, packed NUM_REGIONS*ADDR_W; region i base in slice i (inclusive).
- REGION_LIMIT, {32'h80000,32'h60000,32'h50000,32'h40000}, packed; region i limit in slice i (exclusive).
- TIMEOUT, 255, max cycles waiting for mem_ack; 8-bit counter.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  access request; held until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data; valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  error flag; valid with cpu_ready.
- mem_select  out  NUM_REGIONS  one-hot slave select; registered.
- mem_addr  out  ADDR_W  cpu_addr minus selected base.
- mem_we  out  1  write strobe to the selected slave.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  NUM_REGIONS*DATA_W  per-slave read data; slice i belongs to slave i.
- mem_ack  in  NUM_REGIONS  per-slave completion.

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; timeout counter 0.
- Decode (combinational, internal): region i hits when REGION_BASE[i] <= cpu_addr < REGION_LIMIT[i], unsigned compare.
  - Overlapping windows: the lowest index wins.
  - Empty window (base >= limit): never hits.
- FSM IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - cpu_req=1 with a hit: latch one-hot select, offset, we and wdata into mem_*; go to ACCESS next edge.
  - cpu_req=1 with no hit: go to RESP with err=1; mem_select stays 0.
- ACCESS:
  - mem_select, mem_addr, mem_wdata and mem_we hold stable.
  - mem_ack[sel]=1: capture mem_rdata slice sel (reads only; writes return 0); go to RESP.
  - Acks from unselected slaves are ignored.
  - Counter increments each ACCESS cycle; reaching TIMEOUT with no ack: go to RESP with err=1, rdata 0.
- RESP:
  - cpu_ready=1 and cpu_err valid for exactly one cycle; mem_select and mem_we cleared; return to IDLE.
  - cpu_req still high in this cycle is not a new request; the master must drop it or re-present it in IDLE.
- Latency: minimum 3 cycles from req to ready (ack in the first ACCESS cycle); decode error takes 2 cycles.
- An ack arriving on the same edge as the timeout: the ack wins, err=0.
- Reset asserted mid-ACCESS: immediate return to IDLE, no cpu_ready pulse; the in-flight slave access is abandoned.
- cpu_addr and cpu_wdata are sampled only in IDLE; changes afterwards are ignored.

Optional Feature:
- Macro MEM_ROUTER_ALIGN_CHECK_EN.
- Defined: in IDLE, cpu_addr[1:0] != 0 is treated as a decode error (RESP, err=1, no slave selected), even when the address hits a region.
- Undefined: low address bits pass through into mem_addr unchecked.

Test Plan:
- Read 0x0003_FFFC, slave0 acks 1 cycle after select with 0xDEADBEEF -> mem_select=0001, mem_addr=0x3FFFC, cpu_rdata=0xDEADBEEF, cpu_err=0, ready 3 cycles after req.
- Write 0x0004_0010 data 0x12345678, slave1 acks after 4 cycles -> mem_select=0010, mem_addr=0x10, mem_we=1 held until ack, ready with err=0.
- Read 0x0009_0000 (no region) -> mem_select never asserted, cpu_ready+cpu_err=1 two cycles after req.
- Read 0x0005_0000 with slave2 never acking -> cpu_err=1 after TIMEOUT=255 ACCESS cycles; a spurious mem_ack[0] during the wait is ignored.
- reset_n low during ACCESS to region3 -> all outputs 0 asynchronously, no ready pulse; a following read of 0x0006_0004 completes normally with mem_addr=0x4.
- With MEM_ROUTER_ALIGN_CHECK_EN defined, read 0x0000_0002 -> cpu_err=1 and no select; without it, region0 is selected with mem_addr=0x2.
